// File: rtl/stream_demux_1to2_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_1to2_if
// Description : Handshake bundle for the 1-to-2 word demultiplexer.
//               Carries the input stream (valid/ready/data/sel), both output
//               streams (valid/ready/data) and the two per-output word counts.
//               slave  : seen from the demultiplexer
//               master : seen from the environment driving it
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_demux_1to2_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;

    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;

    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;

    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport slave (
        input  in_valid, in_data, in_sel, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data,
               cnt0, cnt1
    );

    modport master (
        output in_valid, in_data, in_sel, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data,
               cnt0, cnt1
    );
endinterface
`default_nettype wire

// File: rtl/stream_demux_1to2.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_1to2
// Description : Registered 1-to-2 demultiplexer for WIDTH-bit words.
//               Each accepted word is steered by in_sel into a one-entry
//               holding register in front of out0 or out1, so one output can
//               stall while the other keeps draining. A per-output counter
//               tracks how many words were accepted for that output.
// Ports       : clk    - rising-edge clock
//               rst_n  - synchronous reset, active low
//               bus    - stream_demux_1to2_if.slave:
//                        in_valid/in_ready/in_data/in_sel  input stream
//                        out0_valid/out0_ready/out0_data    output 0 stream
//                        out1_valid/out1_ready/out1_data    output 1 stream
//                        cnt0/cnt1                          accepted-word counts
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_1to2 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  wire                   clk,
    input  wire                   rst_n,
    stream_demux_1to2_if.slave    bus
);

    // ------------------------------------------------------------------------
    // Holding registers and counters
    // ------------------------------------------------------------------------
    logic             out0_valid_q, out0_valid_d;
    logic [WIDTH-1:0] out0_data_q,  out0_data_d;
    logic [CNT_W-1:0] cnt0_q,       cnt0_d;

    logic             out1_valid_q, out1_valid_d;
    logic [WIDTH-1:0] out1_data_q,  out1_data_d;
    logic [CNT_W-1:0] cnt1_q,       cnt1_d;

    // ------------------------------------------------------------------------
    // Input handshake
    // ------------------------------------------------------------------------
    logic sel_full;     // selected holding register currently occupied
    logic sel_drain;    // selected holding register empties this edge
    logic in_ready;
    logic accept;
    logic load0;
    logic load1;
    logic drain0;
    logic drain1;

    // Only the selected path gates the input; a stall on the other output
    // never blocks a word headed elsewhere.
    always_comb begin
        sel_full  = bus.in_sel ? out1_valid_q : out0_valid_q;
        sel_drain = bus.in_sel ? bus.out1_ready : bus.out0_ready;
        in_ready  = rst_n & (~sel_full | sel_drain);
        accept    = bus.in_valid & in_ready;
        load0     = accept & ~bus.in_sel;
        load1     = accept &  bus.in_sel;
        drain0    = out0_valid_q & bus.out0_ready;
        drain1    = out1_valid_q & bus.out1_ready;
    end

    // ------------------------------------------------------------------------
    // Output 0 next state
    // A load takes priority over a drain: when the register drains and is
    // refilled on the same edge it simply stays valid with the new word,
    // giving one word per cycle of throughput.
    // ------------------------------------------------------------------------
    always_comb begin
        out0_valid_d = out0_valid_q;
        out0_data_d  = out0_data_q;
        cnt0_d       = cnt0_q;
        if (load0) begin
            out0_valid_d = 1'b1;
            out0_data_d  = bus.in_data;
            cnt0_d       = cnt0_q + CNT_W'(1);   // wraps naturally
        end else if (drain0) begin
            // Data is left in place after a drain; only valid drops.
            out0_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Output 1 next state (same rules as output 0)
    // ------------------------------------------------------------------------
    always_comb begin
        out1_valid_d = out1_valid_q;
        out1_data_d  = out1_data_q;
        cnt1_d       = cnt1_q;
        if (load1) begin
            out1_valid_d = 1'b1;
            out1_data_d  = bus.in_data;
            cnt1_d       = cnt1_q + CNT_W'(1);
        end else if (drain1) begin
            out1_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out0_valid_q <= 1'b0;
            out0_data_q  <= '0;
            cnt0_q       <= '0;
            out1_valid_q <= 1'b0;
            out1_data_q  <= '0;
            cnt1_q       <= '0;
        end else begin
            out0_valid_q <= out0_valid_d;
            out0_data_q  <= out0_data_d;
            cnt0_q       <= cnt0_d;
            out1_valid_q <= out1_valid_d;
            out1_data_q  <= out1_data_d;
            cnt1_q       <= cnt1_d;
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign bus.in_ready   = in_ready;
    assign bus.out0_valid = out0_valid_q;
    assign bus.out0_data  = out0_data_q;
    assign bus.out1_valid = out1_valid_q;
    assign bus.out1_data  = out1_data_q;
    assign bus.cnt0       = cnt0_q;
    assign bus.cnt1       = cnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_demux_1to2.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_demux_1to2
// Description : Directed self-checking bench for stream_demux_1to2.
//               Inputs change 1 time unit after a rising edge; outputs are
//               sampled at that point, well away from the next edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1to2;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    stream_demux_1to2_if #(.WIDTH(32), .CNT_W(16)) bus ();

    stream_demux_1to2 #(.WIDTH(32), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sel = 1'b0;
        bus.in_data = 32'hDEADBEEF;
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        tick();
        tick();
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.out0_valid !== 1'b0) begin failures++; $display("FAIL reset_out0_valid: got %b want 0", bus.out0_valid); end
        checks++; if (bus.out1_valid !== 1'b0) begin failures++; $display("FAIL reset_out1_valid: got %b want 0", bus.out1_valid); end
        checks++; if (bus.out0_data !== 32'h0) begin failures++; $display("FAIL reset_out0_data: got %h want 0", bus.out0_data); end
        checks++; if (bus.out1_data !== 32'h0) begin failures++; $display("FAIL reset_out1_data: got %h want 0", bus.out1_data); end
        checks++; if (bus.cnt0 !== 16'd0) begin failures++; $display("FAIL reset_cnt0: got %0d want 0", bus.cnt0); end
        checks++; if (bus.cnt1 !== 16'd0) begin failures++; $display("FAIL reset_cnt1: got %0d want 0", bus.cnt1); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_single_word();
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sel = 1'b0;
        bus.in_data = 32'hAAAAAAAA;
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready: got %b want 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out0_valid !== 1'b1) begin failures++; $display("FAIL single_out0_valid: got %b want 1", bus.out0_valid); end
        checks++; if (bus.out0_data !== 32'hAAAAAAAA) begin failures++; $display("FAIL single_out0_data: got %h want aaaaaaaa", bus.out0_data); end
        checks++; if (bus.out1_valid !== 1'b0) begin failures++; $display("FAIL single_out1_valid: got %b want 0", bus.out1_valid); end
        checks++; if (bus.cnt0 !== 16'd1) begin failures++; $display("FAIL single_cnt0: got %0d want 1", bus.cnt0); end
        checks++; if (bus.cnt1 !== 16'd0) begin failures++; $display("FAIL single_cnt1: got %0d want 0", bus.cnt1); end
        tick();
        // Drained: valid drops, data keeps its last value.
        checks++; if (bus.out0_valid !== 1'b0) begin failures++; $display("FAIL drain_out0_valid: got %b want 0", bus.out0_valid); end
        checks++; if (bus.out0_data !== 32'hAAAAAAAA) begin failures++; $display("FAIL drain_out0_data: got %h want aaaaaaaa", bus.out0_data); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_stall();
        bus.out1_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sel = 1'b1;
        bus.in_data = 32'h55555555;
        tick();
        bus.in_data = 32'h12345678;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready: got %b want 0", bus.in_ready); end
        tick();
        checks++; if (bus.out1_data !== 32'h55555555) begin failures++; $display("FAIL stall_out1_data: got %h want 55555555", bus.out1_data); end
        checks++; if (bus.out1_valid !== 1'b1) begin failures++; $display("FAIL stall_out1_valid: got %b want 1", bus.out1_valid); end
        checks++; if (bus.cnt1 !== 16'd1) begin failures++; $display("FAIL stall_cnt1: got %0d want 1", bus.cnt1); end
        bus.out1_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL unstall_in_ready: got %b want 1", bus.in_ready); end
        tick();
        // Second word loaded on the same edge the first drained.
        bus.in_valid = 1'b0;
        bus.out1_ready = 1'b0;
        checks++; if (bus.out1_valid !== 1'b1) begin failures++; $display("FAIL unstall_out1_valid: got %b want 1", bus.out1_valid); end
        checks++; if (bus.out1_data !== 32'h12345678) begin failures++; $display("FAIL unstall_out1_data: got %h want 12345678", bus.out1_data); end
        checks++; if (bus.cnt1 !== 16'd2) begin failures++; $display("FAIL unstall_cnt1: got %0d want 2", bus.cnt1); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_independent_paths();
        logic [31:0] w;
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w = 32'hC0DE0000 + 32'(i);
            bus.in_data = w;
            #1;
            checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL indep_in_ready[%0d]: got %b want 1", i, bus.in_ready); end
            tick();
            checks++; if (bus.out0_data !== w || bus.out0_valid !== 1'b1) begin failures++; $display("FAIL indep_out0[%0d]: got v=%b d=%h want v=1 d=%h", i, bus.out0_valid, bus.out0_data, w); end
        end
        bus.in_valid = 1'b0;
        checks++; if (bus.cnt0 !== 16'd5) begin failures++; $display("FAIL indep_cnt0: got %0d want 5", bus.cnt0); end
        checks++; if (bus.cnt1 !== 16'd2) begin failures++; $display("FAIL indep_cnt1: got %0d want 2", bus.cnt1); end
        checks++; if (bus.out1_valid !== 1'b1 || bus.out1_data !== 32'h12345678) begin failures++; $display("FAIL indep_out1_hold: got v=%b d=%h want v=1 d=12345678", bus.out1_valid, bus.out1_data); end
        // Both outputs full: drain them on the same edge.
        bus.out0_ready = 1'b0;
        tick();
        checks++; if (bus.out0_valid !== 1'b1) begin failures++; $display("FAIL hold_out0_valid: got %b want 1", bus.out0_valid); end
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        tick();
        checks++; if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin failures++; $display("FAIL dual_drain: got v0=%b v1=%b want 0 0", bus.out0_valid, bus.out1_valid); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_wrap_stream();
        logic [31:0] sb[$];
        logic [31:0] w;
        logic [31:0] exp_w;
        int          shown;
        shown = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.out1_ready = 1'b1;
        bus.out0_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sel = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            w = (32'(i) * 32'h9E3779B1) ^ 32'h0F0F5A5A;
            bus.in_data = w;
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                failures++;
                if (shown < 10) $display("FAIL stream_in_ready[%0d]: got %b want 1", i, bus.in_ready);
                shown++;
            end else begin
                sb.push_back(w);
            end
            tick();
            if (bus.out1_valid === 1'b1 && sb.size() > 0) begin
                exp_w = sb.pop_front();
                checks++;
                if (bus.out1_data !== exp_w) begin
                    failures++;
                    if (shown < 10) $display("FAIL stream_data[%0d]: got %h want %h", i, bus.out1_data, exp_w);
                    shown++;
                end
            end
            if (i == 65535) begin
                checks++; if (bus.cnt1 !== 16'd0) begin failures++; $display("FAIL stream_cnt1_wrap0: got %0d want 0", bus.cnt1); end
            end
        end
        bus.in_valid = 1'b0;
        checks++; if (bus.cnt1 !== 16'd1) begin failures++; $display("FAIL stream_cnt1_final: got %0d want 1", bus.cnt1); end
        checks++; if (bus.cnt0 !== 16'd0) begin failures++; $display("FAIL stream_cnt0: got %0d want 0", bus.cnt0); end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL stream_scoreboard_left: got %0d words want 0", sb.size()); end
        tick();
        checks++; if (bus.out1_valid !== 1'b0) begin failures++; $display("FAIL stream_tail_valid: got %b want 0", bus.out1_valid); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid();
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sel = 1'b0;
        bus.in_data = 32'h0BADF00D;
        tick();
        bus.in_sel = 1'b1;
        bus.in_data = 32'hFEEDFACE;
        tick();
        checks++; if (bus.out0_valid !== 1'b1 || bus.out1_valid !== 1'b1) begin failures++; $display("FAIL fill_both: got v0=%b v1=%b want 1 1", bus.out0_valid, bus.out1_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL midrst_in_ready: got %b want 0", bus.in_ready); end
        tick();
        checks++; if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got v0=%b v1=%b want 0 0", bus.out0_valid, bus.out1_valid); end
        checks++; if (bus.cnt0 !== 16'd0 || bus.cnt1 !== 16'd0) begin failures++; $display("FAIL midrst_cnt: got %0d %0d want 0 0", bus.cnt0, bus.cnt1); end
        checks++; if (bus.out0_data !== 32'h0 || bus.out1_data !== 32'h0) begin failures++; $display("FAIL midrst_data: got %h %h want 0 0", bus.out0_data, bus.out1_data); end
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin failures++; $display("FAIL postrst_valid[%0d]: got v0=%b v1=%b want 0 0", i, bus.out0_valid, bus.out1_valid); end
        end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sel = 1'b0;
        bus.in_data = 32'h0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        test_reset();
        test_single_word();
        test_stall();
        test_independent_paths();
        test_wrap_stream();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
